// File: rtl/fifo_warb_pkg.sv
// ============================================================================
// Module   : fifo_warb_pkg
// Brief    : Shared types and width helpers for the FIFO write-side arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

package fifo_warb_pkg;

    localparam logic [0:0] ST_ARB   = 1'b0;
    localparam logic [0:0] ST_BURST = 1'b1;

    typedef enum logic [0:0] {
        WARB_ARB   = ST_ARB,
        WARB_BURST = ST_BURST
    } warb_state_e;

    localparam int NREQ_DEF     = 4;
    localparam int MAXBURST_DEF = 4;

    function automatic int owner_width(input int nreq);
        return (nreq > 1) ? $clog2(nreq) : 1;
    endfunction

    // Beat counter must be able to hold MAXBURST itself
    function automatic int beat_width(input int maxburst);
        return (maxburst > 0) ? $clog2(maxburst + 1) : 1;
    endfunction

    localparam int OWNER_W_DEF = owner_width(NREQ_DEF);
    localparam int BEAT_W_DEF  = beat_width(MAXBURST_DEF);

endpackage

`default_nettype wire

// File: rtl/warb_rr_pick.sv
// ============================================================================
// Module   : warb_rr_pick
// Brief    : Combinational rotate-priority picker; first valid index at or
//            after rr_ptr, wrapping modulo NREQ.
// Revision : 1.0
// ============================================================================
`default_nettype none

module warb_rr_pick
    import fifo_warb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int OW   = owner_width(NREQ)
) (
    input  logic [NREQ-1:0] req_valid,
    input  logic [OW-1:0]   rr_ptr,
    output logic [OW-1:0]   grant,
    output logic            any_valid
);

    logic [OW-1:0] w_idx;

    // Scan from the farthest offset down so the nearest valid index wins
    always_comb begin
        grant     = '0;
        any_valid = 1'b0;
        w_idx     = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_idx = OW'((int'(rr_ptr) + k) % NREQ);
            if (req_valid[w_idx]) begin
                grant     = w_idx;
                any_valid = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
// ============================================================================
// Module   : fifo_wr_arbiter
// Brief    : Round-robin, burst-locked arbiter sharing the async FIFO write
//            port. Optional per-requester word counters: WARB_CNT_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fifo_wr_arbiter
    import fifo_warb_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int DSIZE    = 8,
    parameter int MAXBURST = 4
`ifdef WARB_CNT_EN
    ,
    parameter int CNTW     = 16
`endif
) (
    input  logic                     wclk,
    input  logic                     wrst_n,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ-1:0]          req_last,
    input  logic [NREQ*DSIZE-1:0]    req_data,
    output logic [NREQ-1:0]          req_ready,
    input  logic                     wfull,
    output logic                     winc,
    output logic [DSIZE-1:0]         wdata,
    output logic [owner_width(NREQ)-1:0] owner,
    output logic                     busy
`ifdef WARB_CNT_EN
    ,
    output logic [NREQ*CNTW-1:0]     cnt_words
`endif
);

    localparam int OW = owner_width(NREQ);
    localparam int BW = beat_width(MAXBURST);

    warb_state_e   r_state;
    logic [OW-1:0] r_owner;
    logic [BW-1:0] r_beat;
    logic [OW-1:0] r_rr_ptr;

    logic          w_active;
    logic          w_xfer;
    logic          w_release;
    logic [OW-1:0] w_pick;
    logic          w_any;
    logic [OW-1:0] w_next_ptr;

    warb_rr_pick #(
        .NREQ (NREQ),
        .OW   (OW)
    ) u_pick (
        .req_valid (req_valid),
        .rr_ptr    (r_rr_ptr),
        .grant     (w_pick),
        .any_valid (w_any)
    );

    // Gated by reset so an abandoned burst never strobes on the reset cycle
    assign w_active   = (r_state == WARB_BURST) && wrst_n;
    assign w_xfer     = w_active && req_valid[r_owner] && !wfull;
    assign w_release  = w_xfer && (req_last[r_owner] || (r_beat == BW'(MAXBURST - 1)));
    assign w_next_ptr = (r_owner == OW'(NREQ - 1)) ? '0 : r_owner + OW'(1);

    assign winc  = w_xfer;
    assign wdata = req_data[r_owner*DSIZE +: DSIZE];
    assign owner = r_owner;
    assign busy  = (r_state == WARB_BURST);

    always_comb begin
        req_ready = '0;
        if (w_active && !wfull) begin
            req_ready[r_owner] = 1'b1;
        end
    end

    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            r_state  <= WARB_ARB;
            r_owner  <= '0;
            r_beat   <= '0;
            r_rr_ptr <= '0;
        end else begin
            case (r_state)
                WARB_ARB: begin
                    if (w_any) begin
                        r_state <= WARB_BURST;
                        r_owner <= w_pick;
                        r_beat  <= '0;
                    end
                end
                WARB_BURST: begin
                    if (w_release) begin
                        r_state  <= WARB_ARB;
                        r_rr_ptr <= w_next_ptr;
                        r_beat   <= '0;
                    end else if (w_xfer) begin
                        r_beat <= r_beat + BW'(1);
                    end
                end
                default: r_state <= WARB_ARB;
            endcase
        end
    end

`ifdef WARB_CNT_EN
    logic [CNTW-1:0] r_cnt [NREQ];

    generate
        for (genvar i = 0; i < NREQ; i++) begin : g_cnt
            always_ff @(posedge wclk) begin
                if (!wrst_n) begin
                    r_cnt[i] <= '0;
                end else if (w_xfer && (r_owner == OW'(i)) && (r_cnt[i] != '1)) begin
                    r_cnt[i] <= r_cnt[i] + CNTW'(1);
                end
            end
            assign cnt_words[i*CNTW +: CNTW] = r_cnt[i];
        end
    endgenerate
`endif

endmodule

`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
// ============================================================================
// Module   : tb_fifo_wr_arbiter
// Brief    : Randomized scoreboard bench for fifo_wr_arbiter; honours
//            WARB_CNT_EN when defined.
// Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_fifo_wr_arbiter;

    localparam int NREQ     = 4;
    localparam int DSIZE    = 8;
    localparam int MAXBURST = 4;
    localparam int OW       = 2;
    localparam int NCYC     = 4000;
`ifdef WARB_CNT_EN
    localparam int CNTW     = 4;
`endif

    logic                   wclk = 1'b0;
    logic                   wrst_n;
    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_last;
    logic [NREQ*DSIZE-1:0]  req_data;
    logic [NREQ-1:0]        req_ready;
    logic                   wfull;
    logic                   winc;
    logic [DSIZE-1:0]       wdata;
    logic [OW-1:0]          owner;
    logic                   busy;
`ifdef WARB_CNT_EN
    logic [NREQ*CNTW-1:0]   cnt_words;
`endif

    always #5 wclk = ~wclk;

    fifo_wr_arbiter #(
        .NREQ     (NREQ),
        .DSIZE    (DSIZE),
        .MAXBURST (MAXBURST)
`ifdef WARB_CNT_EN
        ,
        .CNTW     (CNTW)
`endif
    ) dut (
        .wclk      (wclk),
        .wrst_n    (wrst_n),
        .req_valid (req_valid),
        .req_last  (req_last),
        .req_data  (req_data),
        .req_ready (req_ready),
        .wfull     (wfull),
        .winc      (winc),
        .wdata     (wdata),
        .owner     (owner),
        .busy      (busy)
`ifdef WARB_CNT_EN
        ,
        .cnt_words (cnt_words)
`endif
    );

    typedef struct {
        int              cyc;
        logic            winc;
        logic [NREQ-1:0] ready;
        logic [OW-1:0]   owner;
        logic            busy;
        logic [DSIZE-1:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   checks  = 0;
    int   errors  = 0;
    bit   running = 1'b1;

    // Reference model: who holds the port, how many words taken, next start
    bit              m_busy;
    int              m_owner;
    int              m_words;
    int              m_start;
    int              m_cnt [NREQ];
    logic [DSIZE-1:0] cur_data [NREQ];
    bit              cur_last [NREQ];
    int              last_pct;

    task automatic new_word(input int i);
        cur_data[i] = DSIZE'($urandom);
        cur_last[i] = ($urandom_range(99) < last_pct);
    endtask

    task automatic model_reset();
        m_busy  = 1'b0;
        m_owner = 0;
        m_words = 0;
        m_start = 0;
        for (int i = 0; i < NREQ; i++) m_cnt[i] = 0;
    endtask

    task automatic model_step(input int c);
        exp_t e;
        int   pick;
        bit   was_last;
        e.cyc   = c;
        e.owner = OW'(m_owner);
        e.busy  = m_busy;
        e.winc  = wrst_n && m_busy && req_valid[m_owner] && !wfull;
        e.ready = (wrst_n && m_busy && !wfull) ? (NREQ'(1) << m_owner) : '0;
        e.data  = cur_data[m_owner];
        exp_q.push_back(e);

        if (!wrst_n) begin
            model_reset();
        end else if (!m_busy) begin
            pick = -1;
            for (int k = 0; k < NREQ; k++) begin
                if (req_valid[(m_start + k) % NREQ]) begin
                    pick = (m_start + k) % NREQ;
                    break;
                end
            end
            if (pick >= 0) begin
                m_busy  = 1'b1;
                m_owner = pick;
                m_words = 0;
            end
        end else if (e.winc) begin
            was_last = cur_last[m_owner];
            m_words++;
`ifdef WARB_CNT_EN
            if (m_cnt[m_owner] < (1 << CNTW) - 1) m_cnt[m_owner]++;
`endif
            new_word(m_owner);
            if (was_last || m_words == MAXBURST) begin
                m_busy  = 1'b0;
                m_start = (m_owner + 1) % NREQ;
            end
        end
    endtask

    task automatic chk(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d actual %0h expected %0h", name, c, act, exp);
        end
    endtask

    // Stimulus: phases of increasing randomness, model predicts each cycle
    initial begin
        int vpct;
        int fpct;
        wrst_n    = 1'b0;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        wfull     = 1'b0;
        last_pct  = 0;
        model_reset();
        for (int i = 0; i < NREQ; i++) new_word(i);

        for (int c = 0; c < NCYC; c++) begin
            @(negedge wclk);
            wrst_n = (c >= 3);
            if (c < 200) begin
                last_pct = 0; vpct = 0; fpct = 0;
            end else if (c < 600) begin
                last_pct = 0; vpct = 100; fpct = 0;
            end else if (c < 1500) begin
                last_pct = 25; vpct = 100; fpct = 30;
            end else begin
                last_pct = 20; vpct = 60; fpct = 25;
                if ($urandom_range(99) == 0) wrst_n = 1'b0;
            end
            for (int i = 0; i < NREQ; i++) begin
                if (c < 200) req_valid[i] = (i == 0);
                else         req_valid[i] = ($urandom_range(99) < vpct);
                req_last[i]                = cur_last[i];
                req_data[i*DSIZE +: DSIZE] = cur_data[i];
            end
            wfull = ($urandom_range(99) < fpct);
            #1;
            model_step(c);
        end
        running = 1'b0;
        @(negedge wclk);
        #5;
        chk("queue_drained", NCYC, 32'(exp_q.size()), 32'd0);
`ifdef WARB_CNT_EN
        for (int i = 0; i < NREQ; i++) begin
            chk("cnt_words", NCYC, 32'(cnt_words[i*CNTW +: CNTW]), 32'(m_cnt[i]));
        end
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Monitor: pops one expectation per cycle and compares DUT outputs
    initial begin
        exp_t e;
        forever begin
            @(negedge wclk);
            #3;
            if (exp_q.size() == 0) begin
                if (running) chk("scoreboard_entry", -1, 32'd0, 32'd1);
            end else begin
                e = exp_q.pop_front();
                chk("winc",      e.cyc, 32'(winc),      32'(e.winc));
                chk("req_ready", e.cyc, 32'(req_ready), 32'(e.ready));
                chk("owner",     e.cyc, 32'(owner),     32'(e.owner));
                chk("busy",      e.cyc, 32'(busy),      32'(e.busy));
                if (e.winc) chk("wdata", e.cyc, 32'(wdata), 32'(e.data));
            end
        end
    end

endmodule

`default_nettype wire
